// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported memory between instruction fetch and load/store.
// Data wins ties unless fetch has waited STARVE_MAX consecutive data grants.
module mem_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_addr,
  output logic [WIDTH-1:0] i_rdata,
  output logic             i_done,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_done,
  output logic             m_valid,
  output logic             m_we,
  output logic [WIDTH-1:0] m_addr,
  output logic [WIDTH-1:0] m_wdata,
  input  logic             m_ready,
  input  logic [WIDTH-1:0] m_rdata,
  output logic             stall_f,
  output logic             stall_m
);

  typedef enum logic [1:0] {ST_IDLE, ST_I_BUSY, ST_D_BUSY, ST_RESP} state_t;

  localparam logic [3:0] LP_SMAX = 4'(STARVE_MAX);

  state_t             r_state;
  logic [3:0]         r_streak;
  logic               r_m_valid;
  logic               r_m_we;
  logic [WIDTH-1:0]   r_m_addr;
  logic [WIDTH-1:0]   r_m_wdata;
  logic [WIDTH-1:0]   r_i_rdata;
  logic [WIDTH-1:0]   r_d_rdata;
  logic               r_i_done;
  logic               r_d_done;
  logic               w_grant_d;

  // Fetch only overrides a pending data request once the streak hits the limit.
  assign w_grant_d = d_req && !(i_req && (r_streak == LP_SMAX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_streak  <= '0;
      r_m_valid <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_i_done  <= 1'b0;
      r_d_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_d) begin
            r_m_valid <= 1'b1;
            r_m_we    <= d_we;
            r_m_addr  <= d_addr;
            r_m_wdata <= d_wdata;
            r_state   <= ST_D_BUSY;
            // Below the limit whenever data wins against a waiting fetch, so no overflow.
            if (i_req) r_streak <= r_streak + 4'd1;
          end else if (i_req) begin
            r_m_valid <= 1'b1;
            r_m_we    <= 1'b0;
            r_m_addr  <= i_addr;
            r_streak  <= '0;
            r_state   <= ST_I_BUSY;
          end
        end
        ST_I_BUSY: begin
          if (m_ready) begin
            r_i_rdata <= m_rdata;
            r_m_valid <= 1'b0;
            r_m_we    <= 1'b0;
            r_i_done  <= 1'b1;
            r_state   <= ST_RESP;
          end
        end
        ST_D_BUSY: begin
          if (m_ready) begin
            if (!r_m_we) r_d_rdata <= m_rdata;
            r_m_valid <= 1'b0;
            r_m_we    <= 1'b0;
            r_d_done  <= 1'b1;
            r_state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_i_done <= 1'b0;
          r_d_done <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_valid = r_m_valid;
  assign m_we    = r_m_we;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;
  assign i_done  = r_i_done;
  assign d_done  = r_d_done;
  assign stall_f = i_req & ~r_i_done;
  assign stall_m = d_req & ~r_d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        m_valid;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic        stall_f;
  logic        stall_m;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_grant;
  logic [31:0] grants [6];
  logic [31:0] exp_grants [6];
  logic        prev_v;

  mem_arbiter #(.WIDTH(32), .STARVE_MAX(4)) u_dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata),
    .stall_f(stall_f), .stall_m(stall_m)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; m_ready = 1'b0; m_rdata = '0;
    exp_grants[0] = 32'h3000; exp_grants[1] = 32'h3000; exp_grants[2] = 32'h3000;
    exp_grants[3] = 32'h3000; exp_grants[4] = 32'h0200; exp_grants[5] = 32'h3000;

    repeat (2) @(posedge clk);
    #1;
    check("rst_mvalid", 32'(m_valid), 32'd0);
    check("rst_mwe",    32'(m_we),    32'd0);
    check("rst_maddr",  m_addr,       32'd0);
    check("rst_mwdata", m_wdata,      32'd0);
    check("rst_irdata", i_rdata,      32'd0);
    check("rst_drdata", d_rdata,      32'd0);
    check("rst_idone",  32'(i_done),  32'd0);
    check("rst_ddone",  32'(d_done),  32'd0);
    reset = 1'b1;

    // Fetch only, memory answers one cycle after m_valid
    i_req = 1'b1; i_addr = 32'h100;
    #1 check("f_stall_req", 32'(stall_f), 32'd1);
    cyc();
    check("f_mvalid", 32'(m_valid), 32'd1);
    check("f_maddr",  m_addr,       32'h100);
    check("f_mwe",    32'(m_we),    32'd0);
    cyc();
    check("f_wait_mvalid", 32'(m_valid), 32'd1);
    check("f_wait_idone",  32'(i_done),  32'd0);
    m_ready = 1'b1; m_rdata = 32'h00500093;
    cyc();
    check("f_idone",  32'(i_done),  32'd1);
    check("f_irdata", i_rdata,      32'h00500093);
    check("f_mvalid_off", 32'(m_valid), 32'd0);
    check("f_stall_done", 32'(stall_f), 32'd0);
    i_req = 1'b0; m_ready = 1'b0;
    cyc();
    check("f_idone_pulse", 32'(i_done), 32'd0);
    check("f_stall_after", 32'(stall_f), 32'd0);

    // Simultaneous store and fetch: store goes first
    i_req = 1'b1; i_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
    cyc();
    check("sf_maddr",  m_addr,       32'h2000);
    check("sf_mwe",    32'(m_we),    32'd1);
    check("sf_mwdata", m_wdata,      32'hDEADBEEF);
    check("sf_stallf", 32'(stall_f), 32'd1);
    check("sf_stallm", 32'(stall_m), 32'd1);
    m_ready = 1'b1; m_rdata = 32'h12345678;
    cyc();
    check("sf_ddone",  32'(d_done), 32'd1);
    check("sf_drdata_store", d_rdata, 32'd0);
    check("sf_stallm_done", 32'(stall_m), 32'd0);
    d_req = 1'b0; d_we = 1'b0; m_ready = 1'b0;
    cyc();
    check("sf_idle_mvalid", 32'(m_valid), 32'd0);
    check("sf_idle_ddone",  32'(d_done),  32'd0);
    cyc();
    check("sf_fetch_mvalid", 32'(m_valid), 32'd1);
    check("sf_fetch_maddr",  m_addr,       32'h104);
    check("sf_fetch_mwe",    32'(m_we),    32'd0);
    m_ready = 1'b1; m_rdata = 32'hCAFE0001;
    cyc();
    check("sf_fetch_idone",  32'(i_done), 32'd1);
    check("sf_fetch_irdata", i_rdata,     32'hCAFE0001);
    i_req = 1'b0; m_ready = 1'b0;
    cyc();

    // Continuous load + fetch: 4 data grants, then one fetch, then data again
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
    m_ready = 1'b1; m_rdata = 32'h11110000;
    n_grant = 0; prev_v = m_valid;
    for (int k = 0; k < 40 && n_grant < 6; k++) begin
      cyc();
      if (m_valid && !prev_v) begin
        grants[n_grant] = m_addr;
        n_grant++;
      end
      prev_v = m_valid;
    end
    check("stv_ngrant", n_grant, 32'd6);
    for (int i = 0; i < 6; i++) check($sformatf("stv_grant%0d", i), grants[i], exp_grants[i]);
    // Requests dropped mid-transaction: the load still completes
    i_req = 1'b0; d_req = 1'b0;
    cyc();
    check("drop_ddone",  32'(d_done), 32'd1);
    check("stv_drdata",  d_rdata,     32'h11110000);
    check("stv_irdata",  i_rdata,     32'h11110000);
    m_ready = 1'b0;
    cyc();
    check("drop_ddone_end", 32'(d_done),  32'd0);
    check("drop_mvalid",    32'(m_valid), 32'd0);

    // Long memory wait in D_BUSY
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000; m_rdata = 32'hFFFF0000;
    cyc();
    for (int k = 0; k < 10; k++) begin
      check($sformatf("wait_mvalid%0d", k), 32'(m_valid), 32'd1);
      check($sformatf("wait_maddr%0d", k),  m_addr,       32'h4000);
      check($sformatf("wait_stallm%0d", k), 32'(stall_m), 32'd1);
      cyc();
    end
    m_ready = 1'b1; m_rdata = 32'h55AA55AA;
    cyc();
    check("wait_ddone",  32'(d_done), 32'd1);
    check("wait_drdata", d_rdata,     32'h55AA55AA);
    d_req = 1'b0; m_ready = 1'b0;
    cyc();
    check("wait_ddone_end", 32'(d_done), 32'd0);

    // Reset during I_BUSY aborts the fetch
    i_req = 1'b1; i_addr = 32'h500;
    cyc();
    check("ab_busy", 32'(m_valid), 32'd1);
    reset = 1'b0;
    #1;
    check("ab_mvalid", 32'(m_valid), 32'd0);
    check("ab_maddr",  m_addr,       32'd0);
    check("ab_irdata", i_rdata,      32'd0);
    check("ab_drdata", d_rdata,      32'd0);
    i_req = 1'b0; m_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc();
      check($sformatf("ab_idone%0d", k), 32'(i_done), 32'd0);
    end
    m_ready = 1'b0;
    i_req = 1'b1; i_addr = 32'h600;
    reset = 1'b1;
    cyc();
    check("rel_grant", 32'(m_valid), 32'd1);
    check("rel_maddr", m_addr,       32'h600);
    m_ready = 1'b1; m_rdata = 32'h0A0A0A0A;
    cyc();
    check("rel_irdata", i_rdata, 32'h0A0A0A0A);
    i_req = 1'b0; m_ready = 1'b0;
    cyc();

    // Stray m_ready in IDLE is ignored
    m_ready = 1'b1; m_rdata = 32'hFFFFFFFF;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check($sformatf("stray_irdata%0d", k), i_rdata,      32'h0A0A0A0A);
      check($sformatf("stray_drdata%0d", k), d_rdata,      32'd0);
      check($sformatf("stray_mvalid%0d", k), 32'(m_valid), 32'd0);
      check($sformatf("stray_done%0d", k),   32'({i_done, d_done}), 32'd0);
    end
    m_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
